// File: rtl/exc_pkg.sv
// Shared constants and the entry layout for the exception monitor.
package exc_pkg;

    localparam int unsigned EXC_CODE_W = 5;
    localparam int unsigned EXC_TS_W   = 32;
    localparam int unsigned EXC_NONE   = 0;

    typedef struct packed {
        logic [EXC_CODE_W-1:0] code;
        logic [EXC_TS_W-1:0]   timestamp;
    } exc_entry_t;

endpackage

// File: rtl/exc_fifo.sv
// Synchronous FIFO with wrap-bit pointers, flush, and no write-to-read bypass.
module exc_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO succeeds.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !flush && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/exception_monitor.sv
// Exception monitor: edge-detects SOC exception codes, keeps sticky/first/count/halt state
// and buffers events in a FIFO. Define EXC_MONITOR_TIMESTAMP_EN to stamp entries with a cycle count.
module exception_monitor
    import exc_pkg::*;
#(
    parameter int unsigned CODE_W         = EXC_CODE_W,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned HALT_THRESHOLD = 4,
    parameter int unsigned TS_W           = EXC_TS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] exception_code,
    input  logic              clear,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [CODE_W-1:0] rd_code,
    output logic [TS_W-1:0]   rd_timestamp,
    output logic              first_valid,
    output logic [CODE_W-1:0] first_code,
    output logic [CNT_W-1:0]  event_count,
    output logic              overflow,
    output logic              halt_req
);

`ifdef EXC_MONITOR_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = CODE_W + TS_W;
`else
    localparam int unsigned ENTRY_W = CODE_W;
`endif

    localparam logic [CNT_W-1:0] HALT_AT = CNT_W'(HALT_THRESHOLD);

    logic [CODE_W-1:0]  prev_code_q;
    logic               first_valid_q, first_valid_d;
    logic [CODE_W-1:0]  first_code_q, first_code_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               halt_q, halt_d;
    logic               event_hit, pop_fire, fifo_full, fifo_empty, fifo_push;
    logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

    assign event_hit = (exception_code != CODE_W'(EXC_NONE)) && (exception_code != prev_code_q);
    assign pop_fire  = !fifo_empty && rd_ready;
    assign fifo_push = event_hit && !clear;

`ifdef EXC_MONITOR_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + 1'b1;
    end

    assign fifo_wdata   = {exception_code, ts_q};
    assign rd_code      = fifo_empty ? '0 : fifo_rdata[ENTRY_W-1 -: CODE_W];
    assign rd_timestamp = fifo_empty ? '0 : fifo_rdata[TS_W-1:0];
`else
    assign fifo_wdata   = exception_code;
    assign rd_code      = fifo_empty ? '0 : fifo_rdata;
    assign rd_timestamp = '0;
`endif

    exc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (clear),
        .push  (fifo_push),
        .pop   (rd_ready),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        first_valid_d = first_valid_q;
        first_code_d  = first_code_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        halt_d        = halt_q;
        if (clear) begin
            first_valid_d = 1'b0;
            first_code_d  = '0;
            count_d       = '0;
            overflow_d    = 1'b0;
            halt_d        = 1'b0;
        end else if (event_hit) begin
            if (count_q != '1) count_d = count_q + 1'b1;
            if (!first_valid_q) begin
                first_valid_d = 1'b1;
                first_code_d  = exception_code;
            end
            if (fifo_full && !pop_fire) overflow_d = 1'b1;
            if ((HALT_AT != '0) && (count_d >= HALT_AT)) halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_code_q   <= '0;
            first_valid_q <= 1'b0;
            first_code_q  <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            halt_q        <= 1'b0;
        end else begin
            // prev_code survives clear so a persisting code does not re-fire.
            prev_code_q   <= exception_code;
            first_valid_q <= first_valid_d;
            first_code_q  <= first_code_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            halt_q        <= halt_d;
        end
    end

    assign rd_valid    = !fifo_empty;
    assign first_valid = first_valid_q;
    assign first_code  = first_code_q;
    assign event_count = count_q;
    assign overflow    = overflow_q;
    assign halt_req    = halt_q;

endmodule

// File: tb/tb_exception_monitor.sv
// Directed bench for exception_monitor (default parameters, timestamp feature off).
module tb_exception_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  exception_code;
    logic        clear;
    logic        rd_ready;
    logic        rd_valid;
    logic [4:0]  rd_code;
    logic [31:0] rd_timestamp;
    logic        first_valid;
    logic [4:0]  first_code;
    logic [15:0] event_count;
    logic        overflow;
    logic        halt_req;

    int checks = 0;
    int errors = 0;

    exception_monitor dut (
        .clk            (clk),
        .reset          (reset),
        .exception_code (exception_code),
        .clear          (clear),
        .rd_ready       (rd_ready),
        .rd_valid       (rd_valid),
        .rd_code        (rd_code),
        .rd_timestamp   (rd_timestamp),
        .first_valid    (first_valid),
        .first_code     (first_code),
        .event_count    (event_count),
        .overflow       (overflow),
        .halt_req       (halt_req)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pop_expect(input string tag, input logic [4:0] code);
        chk({tag, "_valid"}, 32'(rd_valid), 1);
        chk(tag, 32'(rd_code), 32'(code));
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_count"}, 32'(event_count), 0);
        chk({tag, "_first_valid"}, 32'(first_valid), 0);
        chk({tag, "_first_code"}, 32'(first_code), 0);
        chk({tag, "_overflow"}, 32'(overflow), 0);
        chk({tag, "_halt"}, 32'(halt_req), 0);
    endtask

    initial begin
        reset          = 1'b1;
        exception_code = '0;
        clear          = 1'b0;
        rd_ready       = 1'b0;
        step();
        step();
        chk_idle("reset");
        chk("reset_rd_code", 32'(rd_code), 0);
        reset = 1'b0;

        // 1: idle input
        repeat (20) step();
        chk_idle("idle");
        chk("idle_ts", rd_timestamp, 0);

        // 2: held code counts once
        exception_code = 5'd3;
        step();
        chk("hold_count_t1", 32'(event_count), 1);
        chk("hold_first_valid", 32'(first_valid), 1);
        chk("hold_first_code", 32'(first_code), 3);
        chk("hold_rd_valid", 32'(rd_valid), 1);
        repeat (9) step();
        exception_code = 5'd0;
        step();
        chk("hold_count_end", 32'(event_count), 1);
        chk("hold_ts", rd_timestamp, 0);
        pop_expect("hold_pop", 5'd3);
        chk("hold_empty", 32'(rd_valid), 0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_idle("clear1");

        // 3: 2,7,0,2 then a fourth event trips halt
        exception_code = 5'd2; step();
        exception_code = 5'd7; step();
        exception_code = 5'd0; step();
        exception_code = 5'd2; step();
        exception_code = 5'd0; step();
        chk("seq_count", 32'(event_count), 3);
        chk("seq_first", 32'(first_code), 2);
        chk("seq_halt0", 32'(halt_req), 0);
        exception_code = 5'd5; step();
        exception_code = 5'd0;
        chk("seq_count4", 32'(event_count), 4);
        chk("seq_halt1", 32'(halt_req), 1);
        step();
        chk("stable_code", 32'(rd_code), 2);
        pop_expect("seq_pop0", 5'd2);
        pop_expect("seq_pop1", 5'd7);
        pop_expect("seq_pop2", 5'd2);
        pop_expect("seq_pop3", 5'd5);
        chk("seq_empty", 32'(rd_valid), 0);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("empty_ready_valid", 32'(rd_valid), 0);
        chk("halt_sticky", 32'(halt_req), 1);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_idle("clear2");

        // 4: ten events into an 8-deep FIFO
        for (int i = 1; i <= 10; i++) begin
            exception_code = 5'(i);
            step();
        end
        exception_code = 5'd0;
        step();
        chk("ovf_count", 32'(event_count), 10);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_first", 32'(first_code), 1);
        for (int i = 1; i <= 8; i++) pop_expect($sformatf("ovf_pop%0d", i), 5'(i));
        chk("ovf_empty", 32'(rd_valid), 0);

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk_idle("clear3");

        // 5: push and pop on the same cycle while full
        for (int i = 11; i <= 18; i++) begin
            exception_code = 5'(i);
            step();
        end
        exception_code = 5'd0;
        step();
        chk("full_ovf0", 32'(overflow), 0);
        chk("full_count", 32'(event_count), 8);
        exception_code = 5'd19;
        rd_ready       = 1'b1;
        step();
        exception_code = 5'd0;
        rd_ready       = 1'b0;
        chk("pp_ovf", 32'(overflow), 0);
        chk("pp_count", 32'(event_count), 9);
        for (int i = 12; i <= 19; i++) pop_expect($sformatf("pp_pop%0d", i), 5'(i));
        chk("pp_empty", 32'(rd_valid), 0);

        // 6: clear beats a coincident event; held code does not re-fire after clear
        exception_code = 5'd20;
        clear          = 1'b1;
        step();
        clear = 1'b0;
        chk_idle("clear_evt");
        step();
        chk("no_refire", 32'(event_count), 0);
        exception_code = 5'd0;
        step();

        exception_code = 5'd21; step();
        exception_code = 5'd22; step();
        exception_code = 5'd23; step();
        exception_code = 5'd0;  step();
        chk("pre_rst_count", 32'(event_count), 3);
        pop_expect("pre_rst_pop", 5'd21);
        rd_ready = 1'b1;
        reset    = 1'b1;
        step();
        reset    = 1'b0;
        rd_ready = 1'b0;
        chk_idle("mid_reset");
        chk("mid_reset_code", 32'(rd_code), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
